// File: rtl/dechat_pkg.sv
// Shared definitions for the multi-channel debouncer: default widths and the
// encodings of the per-channel hold-to-repeat state machine.
package dechat_pkg;

  localparam int DEF_BW  = 19;
  localparam int DEF_RBW = 24;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_t;

endpackage

// File: rtl/dechat_ch.sv
// One debouncer channel: 2-flop synchroniser, debounce counter, press/release
// pulses and, with DECHAT_MULTI_REPEAT_EN defined, a hold-to-repeat FSM.
module dechat_ch
  import dechat_pkg::*;
#(
  parameter int   BW  = DEF_BW,
  parameter int   RBW = DEF_RBW,
  parameter logic RV  = 1'b1,
  parameter logic ACT = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [BW-1:0]  timeout,
  input  logic [RBW-1:0] rep_delay,
  input  logic [RBW-1:0] rep_rate,
  input  logic           din,
  output logic           dout,
  output logic           press,
  output logic           release_pulse
);

  logic          s1;
  logic          s2;
  logic [BW-1:0] cnt;
  logic          commit;
  logic          press_commit;
  logic          rel_commit;
  logic          rep_fire;

  // The >= keeps a mid-count TIMEOUT reduction from letting cnt run past it.
  assign commit       = (s2 != dout) && (cnt >= timeout);
  assign press_commit = commit && (s2 == ACT);
  assign rel_commit   = commit && (s2 != ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1            <= RV;
      s2            <= RV;
      dout          <= RV;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= din;
      s2            <= s1;
      press         <= press_commit || rep_fire;
      release_pulse <= rel_commit;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (commit) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + BW'(1);
      end
    end
  end

`ifdef DECHAT_MULTI_REPEAT_EN
  rep_state_t     state;
  rep_state_t     state_nxt;
  logic [RBW-1:0] rcnt;
  logic [RBW-1:0] rcnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REP_IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  // A release commit wins over any repeat pulse due in the same cycle.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rep_fire  = 1'b0;
    if (rel_commit) begin
      state_nxt = REP_IDLE;
      rcnt_nxt  = '0;
    end else begin
      case (state)
        REP_IDLE: begin
          if (press_commit) begin
            state_nxt = REP_DELAY;
            rcnt_nxt  = '0;
          end
        end
        REP_DELAY: begin
          if (rcnt >= rep_delay) begin
            rep_fire  = 1'b1;
            rcnt_nxt  = '0;
            state_nxt = REP_REPEAT;
          end else begin
            rcnt_nxt = rcnt + RBW'(1);
          end
        end
        REP_REPEAT: begin
          if (rcnt >= rep_rate) begin
            rep_fire = 1'b1;
            rcnt_nxt = '0;
          end else begin
            rcnt_nxt = rcnt + RBW'(1);
          end
        end
        default: begin
          state_nxt = REP_IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end
  end
`else
  logic unused_rep;

  assign unused_rep = ^{rep_delay, rep_rate};
  assign rep_fire   = 1'b0;
`endif

endmodule

// File: rtl/dechat_multi.sv
// NCH-channel button debouncer with press/release pulses sharing one TIMEOUT.
// Hold-to-repeat is built only when DECHAT_MULTI_REPEAT_EN is defined.
module dechat_multi #(
  parameter int   NCH = 2,
  parameter int   BW  = dechat_pkg::DEF_BW,
  parameter logic RV  = 1'b1,
  parameter logic ACT = 1'b0,
  parameter int   RBW = dechat_pkg::DEF_RBW
) (
  input  logic           CLK,
  input  logic           RSTX,
  input  logic [BW-1:0]  TIMEOUT,
  input  logic [NCH-1:0] DIN,
  output logic [NCH-1:0] DOUT,
  output logic [NCH-1:0] PRESS,
  output logic [NCH-1:0] RELEASE,
  input  logic [RBW-1:0] REP_DELAY,
  input  logic [RBW-1:0] REP_RATE
);

  // Channels are independent; the timing controls fan out to every copy.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    dechat_ch #(
      .BW  (BW),
      .RBW (RBW),
      .RV  (RV),
      .ACT (ACT)
    ) u_ch (
      .clk           (CLK),
      .rst_n         (RSTX),
      .timeout       (TIMEOUT),
      .rep_delay     (REP_DELAY),
      .rep_rate      (REP_RATE),
      .din           (DIN[i]),
      .dout          (DOUT[i]),
      .press         (PRESS[i]),
      .release_pulse (RELEASE[i])
    );
  end

endmodule

// File: doc/dechat_multi.md
Name: dechat_multi

Overview:
- Multi-channel button debouncer; parametrised successor to the single-channel debouncer that feeds pll_ctrl.
- Synchronises and debounces NCH asynchronous inputs, all sharing one runtime TIMEOUT.
- Adds one-cycle PRESS/RELEASE event pulses per channel and optional hold-to-repeat, so controllers can step values without their own edge detectors.

Parameters:
- NCH, 2: number of channels.
- BW, 19: width of the debounce counter and of TIMEOUT.
- RV, 1'b1: reset/idle level of the synchroniser flops and DOUT, applied to all channels.
- ACT, 1'b0: input level that means "pressed".
- RBW, 24: width of the repeat counter, REP_DELAY and REP_RATE.

Ports:
- CLK  in  1  clock.
- RSTX  in  1  reset, asynchronous, active-low.
- TIMEOUT  in  BW  debounce length in cycles minus 1; quasi-static.
- DIN  in  NCH  raw asynchronous inputs.
- DOUT  out  NCH  debounced levels.
- PRESS  out  NCH  one-cycle pulse per press, and per repeat when repeat is enabled.
- RELEASE  out  NCH  one-cycle pulse per release.
- REP_DELAY  in  RBW  hold cycles minus 1 before the first repeat; ignored without the macro.
- REP_RATE  in  RBW  cycles minus 1 between repeats; ignored without the macro.

Behaviour:
- One clock, CLK. RSTX is asynchronous and active-low.
- Reset values: s1, s2 and DOUT = {NCH{RV}}; cnt = 0; PRESS = 0; RELEASE = 0; repeat state = IDLE; rcnt = 0.
- Per channel, 2-flop synchroniser DIN -> s1 -> s2.
- Per channel debounce counter cnt[BW-1:0], evaluated every cycle:
  - if s2 == DOUT: cnt <= 0.
  - else if cnt >= TIMEOUT: commit (DOUT <= s2, cnt <= 0).
  - else: cnt <= cnt + 1.
- The >= comparison means a TIMEOUT lowered mid-count commits on the next cycle; cnt never wraps.
- Latency: a DIN level held stable appears on DOUT TIMEOUT+3 rising edges after it is first sampled. TIMEOUT = 0 gives 3 edges.
- Any return of s2 to the DOUT level before commit clears cnt. Glitches shorter than TIMEOUT+1 cycles never reach DOUT.
- PRESS, RELEASE and DOUT are registered and change on the same edge:
  - PRESS = commit && s2 == ACT.
  - RELEASE = commit && s2 != ACT.
  - Each pulse is exactly one cycle.
- Channels are fully independent; simultaneous commits on several channels pulse all of them in the same cycle.
- If RV == ACT, no pulse is generated out of reset. The first event is RELEASE after a debounced inactive level.
- Async reset mid-count or mid-repeat: all state returns to reset values immediately. No pulse on reset release unless inputs then commit.

Optional Feature:
- Macro DECHAT_MULTI_REPEAT_EN.
- When defined, each channel has a repeat FSM {IDLE, DELAY, REPEAT} with counter rcnt[RBW-1:0]:
  - IDLE: on PRESS commit -> DELAY, rcnt <= 0.
  - DELAY: if rcnt >= REP_DELAY -> PRESS pulse, rcnt <= 0, go to REPEAT; else rcnt + 1.
  - REPEAT: if rcnt >= REP_RATE -> PRESS pulse, rcnt <= 0; else rcnt + 1.
  - Any RELEASE commit -> IDLE, rcnt <= 0, from any state. The release has priority over a repeat pulse in the same cycle.
- Resulting PRESS pulses: press edge t0, then t0+REP_DELAY+1, then every REP_RATE+1 cycles while held.
- When undefined: no FSM or rcnt is synthesised, REP_DELAY and REP_RATE are unconnected internally, and PRESS fires once per press.
- Ports are identical in both builds.

Decomposition:
- Shared header/package dechat_pkg:
  - repeat-state encodings REP_IDLE = 2'd0, REP_DELAY = 2'd1, REP_REPEAT = 2'd2.
  - default widths (BW, RBW).
- One sub-module, dechat_ch: a single channel containing the synchroniser, debounce counter, pulse generation and repeat FSM.
- dechat_multi instantiates NCH copies in a generate loop; TIMEOUT, REP_DELAY and REP_RATE fan out to all channels.

Test Plan:
All scenarios use NCH=2, RV=1, ACT=0, TIMEOUT=4.
- Reset: RSTX low, DIN=2'b00 -> DOUT=2'b11, PRESS=RELEASE=0 immediately; after RSTX rises, no pulse until the first commit.
- Press ch0: DIN[0] 1->0 and held -> DOUT[0] falls exactly 7 edges later, PRESS[0] high for that one cycle only; DOUT[1], PRESS[1] and RELEASE stay 0/idle.
- Bounce: DIN[0] toggles every 3 cycles for 40 cycles, then stays high -> DOUT[0] stays 1, no PRESS or RELEASE.
- Release plus simultaneity: both channels pressed and then released on the same cycle -> RELEASE=2'b11 single-cycle pulse 7 edges later. TIMEOUT=0 -> 3-edge latency.
- Repeat (macro defined), REP_DELAY=9, REP_RATE=3, ch0 held for 30 cycles after commit at t0 -> PRESS[0] at t0, t0+10, t0+14, t0+18, t0+22, t0+26, t0+30; on release, RELEASE pulses and no further PRESS. Without the macro -> only the t0 pulse.
- Mid-operation reset: RSTX pulsed low at cnt=3, and again in REPEAT state -> immediate reset values; after release with DIN still pressed, a fresh TIMEOUT+3 latency before the next PRESS.
